// File: rtl/drum_voice_mixer.sv
// drum_voice_mixer
//   Audio output stage: four trigger-started voices replay samples from an
//   external, time-multiplexed sample memory. Once per 256-clock PWM period
//   the active voices are mixed with saturation; the mix becomes the 8-bit
//   PWM duty from the following period onward.
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   trig[3:0]    voice trigger levels; a rising edge starts/restarts a voice
//   rd_en        sample memory read strobe
//   rd_addr      {voice[1:0], index}; rd_data returns one clock later
//   rd_data      unsigned PCM sample, 0x80 = silence
//   active[3:0]  voice currently playing
//   sample_tick  one-clock pulse while pwm counter is 0
//   duty         current PWM duty
//   pwm_out      registered PWM output
//   mute[3:0]    present only with MIXER_MUTE_EN defined: a muted voice keeps
//                advancing but issues no read and contributes silence
module drum_voice_mixer #(
    parameter int unsigned SAMPLE_LEN = 4000,
    parameter int unsigned IDX_W      = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       trig,
    output logic             rd_en,
    output logic [IDX_W+1:0] rd_addr,
    input  logic [7:0]       rd_data,
    output logic [3:0]       active,
    output logic             sample_tick,
    output logic [7:0]       duty,
    output logic             pwm_out
`ifdef MIXER_MUTE_EN
    ,
    input  logic [3:0]       mute
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_LAST, S_SAT
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              pwm_cnt_q;
    logic [7:0]              duty_q;
    logic [7:0]              duty_nxt_q, duty_nxt_d;
    logic                    pwm_q;
    logic                    tick_q;
    logic [3:0]              trig_q;
    logic [3:0]              pend_q, pend_d;
    logic [3:0]              active_q, active_d;
    logic [3:0]              clr;
    logic [3:0][IDX_W-1:0]   idx_q, idx_d;
    logic signed [9:0]       acc_q, acc_d;
    logic signed [9:0]       smp_s;
    logic                    rd_vld_q, rd_vld_d;
    logic [1:0]              rd_v;
    logic                    rd_slot;
    logic [3:0]              mute_eff;

`ifdef MIXER_MUTE_EN
    assign mute_eff = mute;
`else
    assign mute_eff = '0;
`endif

    // Sample re-centred around zero: 0x80 -> 0.
    assign smp_s = $signed({2'b00, rd_data}) - 10'sd128;

    always_comb begin
        rd_slot = 1'b1;
        rd_v    = 2'd0;
        case (state_q)
            S_RD0:   rd_v = 2'd0;
            S_RD1:   rd_v = 2'd1;
            S_RD2:   rd_v = 2'd2;
            S_RD3:   rd_v = 2'd3;
            default: rd_slot = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        duty_nxt_d = duty_nxt_q;
        active_d   = active_q;
        idx_d      = idx_q;
        clr        = '0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        rd_vld_d   = 1'b0;

        // Data for a read issued last cycle arrives now.
        if (rd_vld_q) begin
            acc_d = acc_q + smp_s;
        end

        if (rd_slot && active_q[rd_v] && !mute_eff[rd_v]) begin
            rd_en    = 1'b1;
            rd_addr  = {rd_v, idx_q[rd_v]};
            rd_vld_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (tick_q) begin
                    state_d = S_RD0;
                    acc_d   = '0;
                end
            end
            S_RD0:  state_d = S_RD1;
            S_RD1:  state_d = S_RD2;
            S_RD2:  state_d = S_RD3;
            S_RD3:  state_d = S_LAST;
            S_LAST: state_d = S_SAT;
            S_SAT: begin
                // Clamp to [-128,127] then offset by 128: the offset is just
                // an inversion of bit 7 of the in-range value.
                if (acc_q > 10'sd127) begin
                    duty_nxt_d = 8'hFF;
                end else if (acc_q < -10'sd128) begin
                    duty_nxt_d = 8'h00;
                end else begin
                    duty_nxt_d = {~acc_q[7], acc_q[6:0]};
                end
                for (int unsigned v = 0; v < 4; v++) begin
                    if (pend_q[v]) begin
                        active_d[v] = 1'b1;
                        idx_d[v]    = '0;
                        clr[v]      = 1'b1;
                    end else if (active_q[v] && idx_q[v] == IDX_W'(SAMPLE_LEN - 1)) begin
                        active_d[v] = 1'b0;
                        idx_d[v]    = '0;
                    end else if (active_q[v]) begin
                        idx_d[v] = idx_q[v] + IDX_W'(1);
                    end
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A rise in the same cycle as the clear keeps the voice pending.
        pend_d = (pend_q & ~clr) | (trig & ~trig_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pwm_cnt_q  <= '0;
            duty_q     <= 8'h80;
            duty_nxt_q <= 8'h80;
            pwm_q      <= 1'b0;
            tick_q     <= 1'b0;
            trig_q     <= '0;
            pend_q     <= '0;
            active_q   <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            rd_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pwm_cnt_q  <= pwm_cnt_q + 8'd1;
            // Registered so the tick lines up with pwm_cnt==0 yet is 0 in reset.
            tick_q     <= (pwm_cnt_q == 8'hFF);
            if (pwm_cnt_q == 8'hFF) begin
                duty_q <= duty_nxt_q;
            end
            duty_nxt_q <= duty_nxt_d;
            pwm_q      <= (pwm_cnt_q < duty_q);
            trig_q     <= trig;
            pend_q     <= pend_d;
            active_q   <= active_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            rd_vld_q   <= rd_vld_d;
        end
    end

    assign active      = active_q;
    assign sample_tick = tick_q;
    assign duty        = duty_q;
    assign pwm_out     = pwm_q;

endmodule

// File: tb/tb_drum_voice_mixer.sv
module tb_drum_voice_mixer;
    localparam int SL = 8;
    localparam int IW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    trig = '0;
    logic          rd_en;
    logic [IW+1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [3:0]    active;
    logic          sample_tick;
    logic [7:0]    duty;
    logic          pwm_out;
    logic [3:0]    mute_v = '0;

    always #5 clk = ~clk;

    drum_voice_mixer #(.SAMPLE_LEN(SL), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .trig(trig), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .active(active), .sample_tick(sample_tick),
        .duty(duty), .pwm_out(pwm_out)
`ifdef MIXER_MUTE_EN
        , .mute(mute_v)
`endif
    );

    logic [7:0] mem [4][SL];
    always @(posedge clk) rd_data <= mem[rd_addr[IW+1:IW]][int'(rd_addr[IW-1:0]) % SL];

    int checks = 0;
    int failures = 0;

    // Reference model: per-voice playback state advanced once per PWM period.
    bit m_act [4];
    int m_idx [4];
    bit m_pend[4];
    bit m_mute[4];
    int m_duty;
    int m_duty_next;
    int first_read;

    typedef struct {
        logic [3:0] mask;
        logic [7:0] val;
        logic [7:0] exp_duty;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int model_active();
        int r = 0;
        for (int v = 0; v < 4; v++) if (m_act[v]) r |= (1 << v);
        return r;
    endfunction

    task automatic reset_model();
        for (int v = 0; v < 4; v++) begin
            m_act[v] = 0; m_idx[v] = 0; m_pend[v] = 0; m_mute[v] = 0;
        end
        m_duty = 128;
        m_duty_next = 128;
    endtask

    task automatic set_trig(input logic [3:0] t);
        for (int v = 0; v < 4; v++) if (t[v] && !trig[v]) m_pend[v] = 1;
        trig = t;
    endtask

    task automatic chk_reset();
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_active", int'(active), 0);
        chk("rst_tick", int'(sample_tick), 0);
        chk("rst_duty", int'(duty), 'h80);
        chk("rst_pwm", int'(pwm_out), 0);
    endtask

    // Expects to be entered at the falling edge where pwm counter is 0,
    // returns at the falling edge where it is 0 again.
    task automatic run_period(input logic [3:0] ta, input int at_a,
                              input logic [3:0] tb, input int at_b,
                              input logic [3:0] mu, input bit rnd);
        int exp_q[$];
        int got_q[$];
        int acc = 0;
        int highs = 0;
        chk("tick_start", int'(sample_tick), 1);
        m_duty = m_duty_next;
        chk("duty_period", int'(duty), m_duty);
        for (int v = 0; v < 4; v++) begin
            if (m_act[v] && !m_mute[v]) begin
                exp_q.push_back(v * 4096 + m_idx[v]);
                acc += int'(mem[v][m_idx[v]]) - 128;
            end
        end
        m_duty_next = (acc > 127) ? 255 : (acc < -128) ? 0 : acc + 128;
        for (int v = 0; v < 4; v++) begin
            if (m_pend[v]) begin
                m_act[v] = 1; m_idx[v] = 0; m_pend[v] = 0;
            end else if (m_act[v] && m_idx[v] == SL - 1) begin
                m_act[v] = 0; m_idx[v] = 0;
            end else if (m_act[v]) begin
                m_idx[v]++;
            end
        end
        for (int c = 1; c <= 256; c++) begin
            @(negedge clk);
            if (c < 256) begin
                if (rd_en) got_q.push_back(int'(rd_addr));
                if (pwm_out) highs++;
            end
            if (c == 10) chk("active", int'(active), model_active());
            if (c == 128) chk("tick_mid", int'(sample_tick), 0);
            if (c == at_a) set_trig(ta);
            if (c == at_b) set_trig(tb);
            if (c == 120) begin
                mute_v = mu;
`ifdef MIXER_MUTE_EN
                for (int v = 0; v < 4; v++) m_mute[v] = mu[v];
`endif
            end
            if (c == 130 && rnd)
                for (int v = 0; v < 4; v++)
                    for (int i = 0; i < SL; i++) mem[v][i] = 8'($urandom);
        end
        chk("nreads", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("rd_addr", got_q[i], exp_q[i]);
        chk("pwm_highs", highs, m_duty);
        first_read = (got_q.size() > 0) ? got_q[0] : -1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_period(trig, -1, trig, -1, mute_v, 0);
    endtask

    task automatic fill(input int v, input logic [7:0] val);
        for (int i = 0; i < SL; i++) mem[v][i] = val;
    endtask

    task automatic release_and_check_pwm();
        int bad = 0;
        rst_n = 1'b1;
        reset_model();
        for (int c = 1; c <= 256; c++) begin
            @(negedge clk);
            if (c < 256 && pwm_out !== ((c <= 128) ? 1'b1 : 1'b0)) bad++;
        end
        chk("pwm_release_pattern", bad, 0);
    endtask

    initial begin
        for (int v = 0; v < 4; v++) fill(v, 8'h80);
        tbl[0] = '{4'b0001, 8'hFF, 8'hFF};
        tbl[1] = '{4'b1111, 8'hFF, 8'hFF};
        tbl[2] = '{4'b1111, 8'h00, 8'h00};
        tbl[3] = '{4'b0010, 8'h90, 8'h90};
        tbl[4] = '{4'b0110, 8'hC0, 8'hFF};
        tbl[5] = '{4'b0101, 8'hA0, 8'hC0};
        tbl[6] = '{4'b1011, 8'h70, 8'h50};
        tbl[7] = '{4'b1100, 8'h20, 8'h00};

        // Power-on reset, then reset in the middle of a read sequence.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset();
        release_and_check_pwm();
        fill(0, 8'hFF);
        run_period(4'b0001, 100, 4'b0001, -1, 4'b0000, 0);
        run_period(4'b0000, 100, 4'b0000, -1, 4'b0000, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset();
        trig = '0;
        repeat (2) @(negedge clk);
        release_and_check_pwm();
        idle(1);
        fill(0, 8'h80);

        // Table: constant-sample voices, expected mixed duty.
        for (int e = 0; e < 8; e++) begin
            int exp_addr = 0;
            for (int v = 3; v >= 0; v--) if (tbl[e].mask[v]) exp_addr = v * 4096;
            for (int v = 0; v < 4; v++) fill(v, tbl[e].mask[v] ? tbl[e].val : 8'h80);
            run_period(tbl[e].mask, 100, tbl[e].mask, -1, mute_v, 0);
            run_period(4'b0000, 100, 4'b0000, -1, mute_v, 0);
            run_period(4'b0000, -1, 4'b0000, -1, mute_v, 0);
            chk("tbl_first_addr", first_read, exp_addr);
            chk("tbl_duty", int'(duty), int'(tbl[e].exp_duty));
            chk("tbl_active", int'(active), int'(tbl[e].mask));
            idle(8);
            chk("tbl_end_active", int'(active), 0);
            chk("tbl_end_duty", int'(duty), 'h80);
        end

        // Retrigger mid-sample, then a rise in the SAT cycle.
        for (int i = 0; i < SL; i++) mem[2][i] = 8'(8'h80 + i * 8);
        run_period(4'b0100, 100, 4'b0100, -1, mute_v, 0);
        run_period(4'b0000, 100, 4'b0000, -1, mute_v, 0);
        idle(5);
        run_period(4'b0100, 100, 4'b0100, -1, mute_v, 0);
        chk("retrig_old_idx", first_read, 'h2005);
        idle(1);
        run_period(4'b0000, 100, 4'b0000, -1, mute_v, 0);
        chk("retrig_addr", first_read, 'h2000);
        run_period(4'b0100, 6, 4'b0100, -1, mute_v, 0);
        run_period(4'b0100, -1, 4'b0100, -1, mute_v, 0);
        chk("sat_rise_deferred", first_read, 'h2002);
        run_period(4'b0000, 100, 4'b0000, -1, mute_v, 0);
        chk("sat_rise_restart", first_read, 'h2000);
        idle(9);

`ifdef MIXER_MUTE_EN
        fill(3, 8'hF0);
        run_period(4'b1000, 100, 4'b1000, -1, 4'b1000, 0);
        run_period(4'b0000, 100, 4'b0000, -1, 4'b1000, 0);
        run_period(4'b0000, -1, 4'b0000, -1, 4'b1000, 0);
        chk("mute_no_read", first_read, -1);
        chk("mute_duty", int'(duty), 'h80);
        chk("mute_active", int'(active), 'h8);
        run_period(4'b0000, -1, 4'b0000, -1, 4'b0000, 0);
        run_period(4'b0000, -1, 4'b0000, -1, 4'b0000, 0);
        chk("unmute_addr", first_read, 'h3002);
        idle(7);
`endif

        // Randomized triggers, mutes and sample contents.
        for (int p = 0; p < 40; p++) begin
            run_period(4'($urandom), $urandom_range(6, 120),
                       4'($urandom), $urandom_range(130, 250),
                       4'($urandom), 1);
        end
        run_period(4'b0000, 50, 4'b0000, -1, 4'b0000, 0);
        idle(9);
        chk("final_active", int'(active), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
